// File: rtl/cpu_flag_pkg.sv
// Shared flag/condition types for the execute stage.
// Used by the flag unit and the branch unit.
package cpu_flag_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    CS = 4'd2,
    CC = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

  function automatic logic uses_flags(cond_e c);
    return !(c inside {AL, NV});
  endfunction

endpackage

// File: rtl/flag_cond_unit_if.sv
// Issue-side bundle between the issue stage and the flag unit.
// Issue stage is master; flag unit is slave.
interface flag_cond_unit_if;

  logic       issue_valid;
  logic       issue_setflags;
  logic [3:0] cond_code;
  logic       stall_o;
  logic       cond_pass;

  modport master (
    output issue_valid,
    output issue_setflags,
    output cond_code,
    input  stall_o,
    input  cond_pass
  );

  modport slave (
    input  issue_valid,
    input  issue_setflags,
    input  cond_code,
    output stall_o,
    output cond_pass
  );

endinterface

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator over NZCV.
// Shared with the branch unit.
module cond_eval
  import cpu_flag_pkg::*;
(
  input  cond_e cond,
  input  nzcv_t flags,
  output logic  pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Tracks in-flight NZCV writers through the adder, commits
// flags, and evaluates the issuing condition with bypass.
module flag_cond_unit
  import cpu_flag_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  flag_cond_unit_if.slave  iss,
  input  logic             flush,
  input  logic             add_n,
  input  logic             add_z,
  input  logic             add_c,
  input  logic             add_v,
  output nzcv_t            flags_q,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [LAT-1:0] pend;
  logic [LAT-1:0] pend_nxt;
  logic           older;
  logic           commit;
  logic           stall;
  logic           take;
  nzcv_t          add_f;
  nzcv_t          eff;
  cond_e          cc;

  assign cc     = cond_e'(iss.cond_code);
  assign add_f  = {add_n, add_z, add_c, add_v};
  assign commit = pend[LAT-1] & ~flush;
  assign eff    = commit ? add_f : flags_q;

  // Only writers still short of the commit slot cause a hazard.
  if (LAT == 1) begin : g_l1
    assign older = 1'b0;
  end else begin : g_ln
    assign older = |pend[LAT-2:0];
  end

  assign stall = iss.issue_valid & uses_flags(cc)
               & older & ~flush;
  assign take  = iss.issue_valid & iss.issue_setflags
               & ~stall;

  assign iss.stall_o = stall;

  always_comb begin
    pend_nxt = (pend << 1) | LAT'(take);
    if (flush) pend_nxt = '0;
  end

  cond_eval u_eval (
    .cond  (cc),
    .flags (eff),
    .pass  (iss.cond_pass)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend    <= '0;
      flags_q <= '0;
    end else begin
      pend <= pend_nxt;
      if (commit) flags_q <= add_f;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt <= '0;
    end else if (stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Execute-stage neighbour that consumes the NZCV outputs of the LAT-deep pipelined adder.
- Tracks flag-setting instructions in flight through the adder and commits NZCV to the architectural flags register.
- Evaluates the 4-bit condition code of the instruction in issue, forwarding flags that arrive this cycle and stalling issue while an older flag write is still inside the adder.

Parameters:
- LAT, 3, adder latency in cycles from issue to valid NZCV; legal range 1..8.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- issue_valid  input  1  instruction presented to the adder this cycle.
- issue_setflags  input  1  that instruction writes NZCV.
- cond_code  input  4  condition of the instruction in issue.
- flush  input  1  kill all in-flight flag writes.
- add_n, add_z, add_c, add_v  input  1 each  adder flag outputs for the instruction issued LAT cycles earlier.
- stall_o  output  1  hold issue this cycle.
- cond_pass  output  1  issuing instruction's condition holds.
- flags_q  output  4  architectural NZCV, bit3=N, bit2=Z, bit1=C, bit0=V.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (asynchronous, n_rst=0): pend=0, flags_q=4'b0000, stall_cnt=0.
- Reset outputs: stall_o=0 and cond_pass=eval(cond_code, 0000).
- Tracking:
  - pend[LAT-1:0] is a shift register.
  - pend[0] <= issue_valid & issue_setflags & ~stall_o & ~flush.
  - pend[k] <= pend[k-1] & ~flush.
  - pend[LAT-1]=1 marks the cycle in which add_* are valid for a flag writer.
- Commit: if pend[LAT-1] & ~flush, flags_q <= {add_n,add_z,add_c,add_v} at the next edge; otherwise flags_q holds.
- Effective flags eff = (pend[LAT-1] & ~flush) ? add_* : flags_q. This is a combinational bypass.
- Hazard:
  - stall_o = issue_valid & uses_flags(cond_code) & (|pend[LAT-2:0]) & ~flush.
  - uses_flags is false for AL (14) and NV (15).
  - For LAT=1, stall_o is constantly 0.
- cond_pass = eval(cond_code, eff), combinational. It is don't-care while stall_o=1.
- eval decode:
  - EQ 0: Z
  - NE 1: ~Z
  - CS 2: C
  - CC 3: ~C
  - MI 4: N
  - PL 5: ~N
  - VS 6: V
  - VC 7: ~V
  - HI 8: C&~Z
  - LS 9: ~C|Z
  - GE 10: N==V
  - LT 11: N!=V
  - GT 12: ~Z&(N==V)
  - LE 13: Z|(N!=V)
  - AL 14: 1
  - NV 15: 0
- Stalled issue: a stalled issue does not enter pend. Upstream re-presents the same instruction next cycle.
- Flush:
  - Applies to every in-flight entry, including the one committing this cycle; its write is dropped.
  - Same-cycle issue is dropped.
  - flags_q is never altered by flush.
- Back-to-back writers: each commits in order, one per cycle. The latest commit wins the bypass.
- stall_cnt: increments on each cycle with stall_o=1, saturates at all-ones, and is cleared only by reset.
- Reset mid-operation: all pending writes are discarded and flags_q returns to 0.

Decomposition:
- Shared package cpu_flag_pkg:
  - typedef cond_e (4-bit enum EQ..NV).
  - Localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef nzcv_t (logic [3:0]).
- One sub-module, cond_eval: purely combinational (cond_e, nzcv_t) -> pass. It is reused by the branch unit.
- Flag and pend registers use the team's standard resettable DFF block.

Test Plan:
- Reset then cond_code=EQ, no writers -> cond_pass=0, flags_q=0000, stall_o=0.
- Subtract-with-flags issue of 5-5 at cycle 0 (LAT=3), EQ queried from cycle 1:
  - stall_o=1 in cycles 1-2; stall_cnt=2.
  - Cycle 3: cond_pass=1 via bypass.
  - Cycle 4: flags_q=0110.
- Writers at cycles 0 and 1, with adder flags 1000 then 0001, no queries -> flags_q=1000 after cycle 3, 0001 after cycle 4.
- Flag writer issued at cycle 0, flush at cycle 2 -> pend clears; flags_q unchanged at 0000 through cycle 6; stall_o=0 from cycle 2.
- Sweep all 16 cond_code values over all 16 flag combinations with pend idle -> cond_pass matches decode table; AL never stalls, even with pend non-zero.
- Hold stall with LAT=3, CNT_W=2 for 6 cycles -> stall_cnt reaches 3 and stays.
- Assert n_rst mid-flight with pend=111 -> outputs reach reset values immediately, and no commit follows release.
